// File: rtl/period_meter.sv
// rtl/period_meter.sv - measures the period of a slow sensor pulse in clk cycles
//
// Purpose:
//   Counts clk cycles between rising edges of an asynchronous, slow sensor
//   pulse (hall / index sensor). Edges that arrive closer than MIN_PERIOD to
//   the last accepted edge are treated as glitches and ignored. If no edge
//   arrives within MAX_PERIOD cycles, the meter reports a timeout, drops lock
//   and waits for a fresh edge to re-arm.
//
// Ports:
//   clk           in   1      system clock
//   rst           in   1      asynchronous, active-low reset
//   sense_in      in   1      asynchronous sensor pulse; rising edge = one revolution
//   period        out  CNT_W  last accepted period in clk cycles, held between updates
//   period_valid  out  1      one-cycle pulse when period is updated
//   locked        out  1      high after the first accepted period, cleared on timeout
//   timeout       out  1      one-cycle pulse when no edge arrives within MAX_PERIOD

module period_meter #(
  parameter int CNT_W      = 24,
  parameter int MIN_PERIOD = 1000,
  parameter int MAX_PERIOD = 10_000_000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sense_in,
  output logic [CNT_W-1:0] period,
  output logic             period_valid,
  output logic             locked,
  output logic             timeout
);

  localparam logic [CNT_W-1:0] MIN_CNT = CNT_W'(MIN_PERIOD);
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_PERIOD);
  localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

  typedef enum logic {
    IDLE,
    MEASURE
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] counter;

  // Two-stage synchronizer plus one delay stage for edge detection.
  logic sync1;
  logic sync2;
  logic sync2_d;
  logic rise;

  assign rise = sync2 & ~sync2_d;

  // The counter is loaded with 1 on an accepted edge, so at the next accepted
  // edge it holds exactly the number of clk cycles between the two edges.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1        <= 1'b0;
      sync2        <= 1'b0;
      sync2_d      <= 1'b0;
      state        <= IDLE;
      counter      <= '0;
      period       <= '0;
      period_valid <= 1'b0;
      locked       <= 1'b0;
      timeout      <= 1'b0;
    end else begin
      sync1        <= sense_in;
      sync2        <= sync1;
      sync2_d      <= sync2;
      period_valid <= 1'b0;
      timeout      <= 1'b0;

      case (state)
        IDLE: begin
          // First edge only arms the meter; there is no reference yet.
          if (rise) begin
            counter <= ONE;
            state   <= MEASURE;
          end else begin
            counter <= '0;
          end
        end

        MEASURE: begin
          // An edge takes priority over the timeout check, so an edge landing
          // exactly at MAX_PERIOD is still a valid measurement.
          if (rise && (counter >= MIN_CNT)) begin
            period       <= counter;
            period_valid <= 1'b1;
            locked       <= 1'b1;
            counter      <= ONE;
          end else if (rise) begin
            // Glitch: keep counting from the last accepted edge.
            counter <= counter + ONE;
          end else if (counter == MAX_CNT) begin
            timeout <= 1'b1;
            locked  <= 1'b0;
            counter <= '0;
            state   <= IDLE;
          end else begin
            counter <= counter + ONE;
          end
        end

        default: begin
          counter <= '0;
          state   <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_period_meter.sv
// tb/tb_period_meter.sv - scoreboard testbench for period_meter

module tb_period_meter;

  localparam int CNT_W      = 8;
  localparam int MIN_PERIOD = 8;
  localparam int MAX_PERIOD = 100;

  logic             clk;
  logic             rst;
  logic             sense_in;
  logic [CNT_W-1:0] period;
  logic             period_valid;
  logic             locked;
  logic             timeout;

  period_meter #(
    .CNT_W     (CNT_W),
    .MIN_PERIOD(MIN_PERIOD),
    .MAX_PERIOD(MAX_PERIOD)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .sense_in    (sense_in),
    .period      (period),
    .period_valid(period_valid),
    .locked      (locked),
    .timeout     (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    bit is_to;
    int per;
    int cyc;
  } ev_t;

  ev_t exp_q[$];
  ev_t ev;

  int checks = 0;
  int errors = 0;

  // Reference model state: time stamps of accepted edges, not a counter.
  int cyc = 0;
  bit smp1 = 0, smp2 = 0, smp3 = 0;
  bit armed = 0;
  int last_acc = 0;
  int m_period = 0;
  bit m_locked = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual %0d required %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // A sensor level sampled at clk edge k is seen as a rising edge by the
  // meter's decision at edge k+2; the model acts on time stamps from there.
  always @(posedge clk) begin
    cyc = cyc + 1;
    if (!rst) begin
      smp1 = 0; smp2 = 0; smp3 = 0;
      armed = 0; m_locked = 0; m_period = 0;
    end else begin
      bit r;
      r = smp2 & ~smp3;
      smp3 = smp2; smp2 = smp1; smp1 = sense_in;
      if (r) begin
        if (!armed) begin
          armed = 1;
          last_acc = cyc;
        end else if (cyc - last_acc >= MIN_PERIOD) begin
          m_period = cyc - last_acc;
          m_locked = 1;
          exp_q.push_back('{is_to: 1'b0, per: m_period, cyc: cyc});
          last_acc = cyc;
        end
      end else if (armed && (cyc - last_acc == MAX_PERIOD)) begin
        armed = 0;
        m_locked = 0;
        exp_q.push_back('{is_to: 1'b1, per: m_period, cyc: cyc});
      end
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      chk("locked", int'(locked), int'(m_locked));
      chk("period_hold", int'(period), m_period);
      if (period_valid || timeout) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_output", 1, 0);
        end else begin
          ev = exp_q.pop_front();
          chk("kind_timeout", int'(timeout), int'(ev.is_to));
          chk("kind_valid", int'(period_valid), int'(!ev.is_to));
          chk("event_cycle", cyc, ev.cyc);
          chk("event_period", int'(period), ev.per);
        end
      end else if (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
        chk("missed_event_cycle", cyc, exp_q[0].cyc);
        void'(exp_q.pop_front());
      end
    end
  end

  task automatic wave(input int hi, input int lo);
    sense_in = 1'b1;
    repeat (hi) @(negedge clk);
    sense_in = 1'b0;
    repeat (lo) @(negedge clk);
  endtask

  initial begin
    rst = 1'b0;
    sense_in = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_period", int'(period), 0);
    chk("reset_valid", int'(period_valid), 0);
    chk("reset_locked", int'(locked), 0);
    chk("reset_timeout", int'(timeout), 0);
    #2 rst = 1'b1;
    @(negedge clk);

    // Square wave of period 40; first edge arms only.
    repeat (4) wave(20, 20);
    chk("sq40_period", int'(period), 40);
    chk("sq40_locked", int'(locked), 1);

    // Glitch 5 clk after an accepted edge, real edge at +40.
    wave(2, 3);
    wave(2, 33);
    wave(20, 20);
    chk("glitch_period", int'(period), 40);

    // Edge at +7 rejected, edge 8 later measures 15; then an 8-cycle period.
    wave(3, 4);
    wave(4, 4);
    wave(4, 4);
    chk("reject7_period", int'(period), 15);
    wave(4, 4);
    chk("min8_period", int'(period), 8);

    // Lock at 40, stop the input, expect timeout with period held.
    wave(20, 20);
    wave(20, 20);
    repeat (120) @(negedge clk);
    chk("timeout_locked", int'(locked), 0);
    chk("timeout_period", int'(period), 40);
    wave(10, 20);
    wave(10, 20);
    chk("relock_period", int'(period), 30);
    chk("relock_locked", int'(locked), 1);

    // Edge arriving exactly at the timeout boundary.
    wave(50, 50);
    wave(50, 50);
    chk("max_period", int'(period), 100);
    repeat (110) @(negedge clk);

    // Reset in the middle of a measurement with the input toggling.
    repeat (3) wave(5, 15);
    sense_in = 1'b1;
    repeat (3) @(negedge clk);
    #1 rst = 1'b0;
    #1;
    chk("midreset_period", int'(period), 0);
    chk("midreset_valid", int'(period_valid), 0);
    chk("midreset_locked", int'(locked), 0);
    chk("midreset_timeout", int'(timeout), 0);
    repeat (2) wave(3, 3);
    #2 rst = 1'b1;
    wave(20, 20);
    chk("rearm_locked", int'(locked), 0);
    repeat (2) wave(20, 20);
    chk("after_reset_period", int'(period), 40);

    // Randomized traffic around the glitch and timeout boundaries.
    for (int i = 0; i < 250; i++) begin
      int sel;
      sel = int'($urandom_range(0, 39));
      if (sel == 0) begin
        #1 rst = 1'b0;
        repeat (2) @(negedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
      end else if (sel < 12) begin
        wave(int'($urandom_range(1, 4)), int'($urandom_range(2, 6)));
      end else if (sel < 16) begin
        wave(int'($urandom_range(1, 30)), int'($urandom_range(90, 130)));
      end else begin
        wave(int'($urandom_range(1, 30)), int'($urandom_range(1, 60)));
      end
    end

    sense_in = 1'b0;
    repeat (150) @(negedge clk);
    chk("queue_drained", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
